// File: rtl/wb_unalign_split_pkg.sv
// Shared definitions for the unaligned-access splitter.
//   ADR_W_DEFAULT : default Wishbone byte-address width
//   state_e       : splitter FSM state encoding
//   is_split()    : true when a CPU access must become two byte accesses
package wb_unalign_split_pkg;

    localparam int ADR_W_DEFAULT = 20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SINGLE = 3'd1,
        ST_LO     = 3'd2,
        ST_GAP    = 3'd3,
        ST_HI     = 3'd4,
        ST_ACK    = 3'd5
    } state_e;

    // A word access to an odd byte address cannot be issued as one
    // downstream word access, so it is broken into low and high bytes.
    function automatic logic is_split(input logic byte_acc, input logic adr_lsb);
        return !byte_acc && adr_lsb;
    endfunction

endpackage

// File: rtl/wb_unalign_split.sv
// Wishbone bridge between the CPU master and the memory map. Word accesses
// to odd addresses are split into a low-byte access at adr and a high-byte
// access at adr+1, separated by one idle strobe cycle. All other accesses
// pass through as a single downstream access. Every output is registered.
//
// Ports
//   clk_i, rst_i         : clock, synchronous active-high reset
//   adr_i, dat_i, we_i,
//   byte_i, stb_i        : CPU request
//   dat_o, ack_o         : CPU read data and one-cycle acknowledge
//   m_adr_o, m_dat_o,
//   m_we_o, m_byte_o,
//   m_stb_o              : memory-map request (byte data on bits [7:0])
//   m_dat_i, m_ack_i     : memory-map read data and acknowledge
//
// state  | meaning
// IDLE   | waiting for stb_i; request is latched on acceptance
// SINGLE | one pass-through access outstanding
// LO     | low byte of a split access outstanding (at adr)
// GAP    | one cycle with m_stb_o low between the two byte accesses
// HI     | high byte of a split access outstanding (at adr+1)
// ACK    | ack_o high for this single cycle, then back to IDLE
module wb_unalign_split
    import wb_unalign_split_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [15:0]      dat_i,
    output logic [15:0]      dat_o,
    input  logic             we_i,
    input  logic             byte_i,
    input  logic             stb_i,
    output logic             ack_o,
    output logic [ADR_W-1:0] m_adr_o,
    output logic [15:0]      m_dat_o,
    input  logic [15:0]      m_dat_i,
    input  logic             m_ack_i,
    output logic             m_we_o,
    output logic             m_byte_o,
    output logic             m_stb_o
);

    state_e           state_q;
    logic [ADR_W-1:0] adr_q;
    logic [15:0]      dat_q;
    logic             we_q;

    // Address of the high byte; the natural width truncation gives the
    // wrap from the top of the address space back to zero.
    logic [ADR_W-1:0] adr_hi_d;
    assign adr_hi_d = adr_q + ADR_W'(1);

    // An acknowledge only counts while a downstream strobe is out.
    logic m_ack_valid;
    assign m_ack_valid = m_ack_i && m_stb_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            dat_o    <= '0;
            ack_o    <= 1'b0;
            m_adr_o  <= '0;
            m_dat_o  <= '0;
            m_we_o   <= 1'b0;
            m_byte_o <= 1'b0;
            m_stb_o  <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (stb_i) begin
                        adr_q   <= adr_i;
                        dat_q   <= dat_i;
                        we_q    <= we_i;
                        m_adr_o <= adr_i;
                        m_we_o  <= we_i;
                        m_stb_o <= 1'b1;
                        if (is_split(byte_i, adr_i[0])) begin
                            m_dat_o  <= {8'h00, dat_i[7:0]};
                            m_byte_o <= 1'b1;
                            state_q  <= ST_LO;
                        end else begin
                            m_dat_o  <= dat_i;
                            m_byte_o <= byte_i;
                            state_q  <= ST_SINGLE;
                        end
                    end
                end

                ST_SINGLE: begin
                    if (m_ack_valid) begin
                        dat_o   <= m_dat_i;
                        m_stb_o <= 1'b0;
                        ack_o   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end

                ST_LO: begin
                    if (m_ack_valid) begin
                        // Split writes leave the CPU read data untouched.
                        if (!we_q) begin
                            dat_o[7:0] <= m_dat_i[7:0];
                        end
                        m_stb_o <= 1'b0;
                        state_q <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    m_adr_o  <= adr_hi_d;
                    m_dat_o  <= {8'h00, dat_q[15:8]};
                    m_byte_o <= 1'b1;
                    m_stb_o  <= 1'b1;
                    state_q  <= ST_HI;
                end

                ST_HI: begin
                    if (m_ack_valid) begin
                        if (!we_q) begin
                            dat_o[15:8] <= m_dat_i[7:0];
                        end
                        m_stb_o <= 1'b0;
                        ack_o   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    m_stb_o <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_unalign_split.sv
module tb_wb_unalign_split;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr;
    logic [15:0]   dat_w;
    logic [15:0]   dat_r;
    logic          we;
    logic          byte_acc;
    logic          stb;
    logic          ack;
    logic [AW-1:0] m_adr;
    logic [15:0]   m_dat_w;
    logic [15:0]   m_dat_r;
    logic          m_ack;
    logic          m_we;
    logic          m_byte;
    logic          m_stb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_unalign_split #(.ADR_W(AW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .adr_i    (adr),
        .dat_i    (dat_w),
        .dat_o    (dat_r),
        .we_i     (we),
        .byte_i   (byte_acc),
        .stb_i    (stb),
        .ack_o    (ack),
        .m_adr_o  (m_adr),
        .m_dat_o  (m_dat_w),
        .m_dat_i  (m_dat_r),
        .m_ack_i  (m_ack),
        .m_we_o   (m_we),
        .m_byte_o (m_byte),
        .m_stb_o  (m_stb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven at negedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ack"},    32'(ack),     32'h0);
        chk({tag, " m_stb"},  32'(m_stb),   32'h0);
        chk({tag, " dat_o"},  32'(dat_r),   32'h0);
        chk({tag, " m_adr"},  32'(m_adr),   32'h0);
        chk({tag, " m_dat"},  32'(m_dat_w), 32'h0);
        chk({tag, " m_we"},   32'(m_we),    32'h0);
        chk({tag, " m_byte"}, 32'(m_byte),  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; adr = '0; dat_w = '0; we = 1'b0; byte_acc = 1'b0;
        stb = 1'b0; m_dat_r = '0; m_ack = 1'b0;
        cyc(); cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        // Stray m_ack_i in IDLE must be ignored.
        m_ack = 1'b1; m_dat_r = 16'hDEAD;
        cyc();
        m_ack = 1'b0;
        cyc();
        chk("idle_ack ack", 32'(ack), 32'h0);
        chk("idle_ack m_stb", 32'(m_stb), 32'h0);
        chk("idle_ack dat_o", 32'(dat_r), 32'h0);

        // Aligned word read @0x00400 -> 0xBEEF, ack on cycle 3.
        adr = 20'h00400; we = 1'b0; byte_acc = 1'b0; stb = 1'b1;
        cyc();                                   // cycle 1
        chk("rd_al m_stb c1", 32'(m_stb), 32'h1);
        chk("rd_al m_adr", 32'(m_adr), 32'h00400);
        chk("rd_al m_byte", 32'(m_byte), 32'h0);
        chk("rd_al m_we", 32'(m_we), 32'h0);
        chk("rd_al ack c1", 32'(ack), 32'h0);
        adr = 20'h0FFFF;                         // must be ignored after acceptance
        cyc();                                   // cycle 2
        chk("rd_al m_stb c2", 32'(m_stb), 32'h1);
        m_ack = 1'b1; m_dat_r = 16'hBEEF;
        cyc();                                   // cycle 3
        m_ack = 1'b0;
        chk("rd_al ack c3", 32'(ack), 32'h1);
        chk("rd_al dat_o", 32'(dat_r), 32'hBEEF);
        chk("rd_al m_stb c3", 32'(m_stb), 32'h0);
        stb = 1'b0;
        cyc();                                   // cycle 4
        chk("rd_al ack c4", 32'(ack), 32'h0);
        cyc();

        // Split write 0x1234 @0x00401.
        adr = 20'h00401; dat_w = 16'h1234; we = 1'b1; byte_acc = 1'b0; stb = 1'b1;
        cyc();                                   // cycle 1: LO
        chk("wr_sp lo m_stb", 32'(m_stb), 32'h1);
        chk("wr_sp lo m_adr", 32'(m_adr), 32'h00401);
        chk("wr_sp lo m_byte", 32'(m_byte), 32'h1);
        chk("wr_sp lo m_we", 32'(m_we), 32'h1);
        chk("wr_sp lo m_dat", 32'(m_dat_w[7:0]), 32'h34);
        cyc();                                   // cycle 2
        m_ack = 1'b1;
        cyc();                                   // cycle 3: GAP
        m_ack = 1'b0;
        chk("wr_sp gap m_stb", 32'(m_stb), 32'h0);
        chk("wr_sp gap ack", 32'(ack), 32'h0);
        cyc();                                   // cycle 4: HI
        chk("wr_sp hi m_stb", 32'(m_stb), 32'h1);
        chk("wr_sp hi m_adr", 32'(m_adr), 32'h00402);
        chk("wr_sp hi m_byte", 32'(m_byte), 32'h1);
        chk("wr_sp hi m_dat", 32'(m_dat_w[7:0]), 32'h12);
        chk("wr_sp hi ack", 32'(ack), 32'h0);
        cyc();                                   // cycle 5
        m_ack = 1'b1;
        cyc();                                   // cycle 6: ACK
        m_ack = 1'b0;
        chk("wr_sp ack c6", 32'(ack), 32'h1);
        chk("wr_sp dat_o held", 32'(dat_r), 32'hBEEF);
        stb = 1'b0;
        cyc();
        chk("wr_sp ack c7", 32'(ack), 32'h0);
        cyc();

        // Split read @0x00401: low 0x55CD, high 0x77AB -> 0xABCD.
        adr = 20'h00401; we = 1'b0; byte_acc = 1'b0; stb = 1'b1;
        cyc();
        chk("rd_sp lo m_we", 32'(m_we), 32'h0);
        stb = 1'b0;
        cyc();
        m_ack = 1'b1; m_dat_r = 16'h55CD;
        cyc();                                   // GAP
        m_ack = 1'b0;
        cyc();                                   // HI
        chk("rd_sp hi m_adr", 32'(m_adr), 32'h00402);
        cyc();
        m_ack = 1'b1; m_dat_r = 16'h77AB;
        cyc();                                   // ACK
        m_ack = 1'b0;
        chk("rd_sp ack", 32'(ack), 32'h1);
        chk("rd_sp dat_o", 32'(dat_r), 32'hABCD);
        cyc();
        cyc();

        // Wrap: word read @0xFFFFF -> high byte @0x00000.
        adr = 20'hFFFFF; we = 1'b0; byte_acc = 1'b0; stb = 1'b1;
        cyc();
        stb = 1'b0;
        chk("wrap lo m_adr", 32'(m_adr), 32'hFFFFF);
        m_ack = 1'b1; m_dat_r = 16'h0011;
        cyc();                                   // GAP
        m_ack = 1'b0;
        cyc();                                   // HI
        chk("wrap hi m_adr", 32'(m_adr), 32'h00000);
        m_ack = 1'b1; m_dat_r = 16'h0022;
        cyc();                                   // ACK
        m_ack = 1'b0;
        chk("wrap ack", 32'(ack), 32'h1);
        chk("wrap dat_o", 32'(dat_r), 32'h2211);
        cyc();

        // Byte write @0x00005 passes through as one access.
        adr = 20'h00005; dat_w = 16'h00A5; we = 1'b1; byte_acc = 1'b1; stb = 1'b1;
        cyc();
        stb = 1'b0;
        chk("bwr m_adr", 32'(m_adr), 32'h00005);
        chk("bwr m_byte", 32'(m_byte), 32'h1);
        chk("bwr m_dat", 32'(m_dat_w), 32'h00A5);
        cyc();
        m_ack = 1'b1; m_dat_r = 16'h0000;
        cyc();
        m_ack = 1'b0;
        chk("bwr ack", 32'(ack), 32'h1);
        cyc();

        // Reset during HI with delayed acknowledge.
        adr = 20'h00007; we = 1'b0; byte_acc = 1'b0; stb = 1'b1;
        cyc();                                   // LO
        stb = 1'b0;
        m_ack = 1'b1; m_dat_r = 16'h0033;
        cyc();                                   // GAP
        m_ack = 1'b0;
        cyc();                                   // HI
        chk("rst_hi m_stb", 32'(m_stb), 32'h1);
        cyc();                                   // still HI, no ack yet
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_all_zero("rst_hi");
        m_ack = 1'b1; m_dat_r = 16'h0044;        // late ack, must be ignored
        cyc();
        m_ack = 1'b0;
        chk("rst_hi late ack", 32'(ack), 32'h0);
        chk("rst_hi late m_stb", 32'(m_stb), 32'h0);
        cyc();
        chk("rst_hi no ack", 32'(ack), 32'h0);

        // Byte read @0x00003 after reset.
        adr = 20'h00003; we = 1'b0; byte_acc = 1'b1; stb = 1'b1;
        cyc();
        stb = 1'b0;
        chk("brd m_adr", 32'(m_adr), 32'h00003);
        chk("brd m_byte", 32'(m_byte), 32'h1);
        chk("brd m_stb", 32'(m_stb), 32'h1);
        cyc();
        m_ack = 1'b1; m_dat_r = 16'h0042;
        cyc();
        m_ack = 1'b0;
        chk("brd ack", 32'(ack), 32'h1);
        chk("brd dat_o", 32'(dat_r), 32'h0042);
        cyc();
        chk("brd ack done", 32'(ack), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_unalign_split.md
WB_UNALIGN_SPLIT -- requirements
Module: wb_unalign_split

Interface
REQ-001 The block SHALL have one parameter: ADR_W, default 20, Wishbone byte-address width.
REQ-002 The block SHALL have port clk_i, input, 1, the only clock; all logic acts on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, reset; it is synchronous and active-high.
REQ-004 The block SHALL have ports adr_i, input, ADR_W, CPU byte address.
REQ-005 The block SHALL have ports dat_i, input, 16, CPU write data, and dat_o, output, 16, CPU read data.
REQ-006 The block SHALL have ports we_i, input, 1, CPU write enable.
REQ-007 The block SHALL have ports byte_i, input, 1, CPU byte access when high.
REQ-008 The block SHALL have ports stb_i, input, 1, CPU strobe, and ack_o, output, 1, CPU acknowledge.
REQ-009 The block SHALL have ports m_adr_o, output, ADR_W, and m_dat_o, output, 16, memory-map address and write data.
REQ-010 The block SHALL have ports m_dat_i, input, 16, and m_ack_i, input, 1, memory-map read data and acknowledge.
REQ-011 The block SHALL have ports m_we_o, m_byte_o and m_stb_o, each output, 1, memory-map write enable, byte flag and strobe.

Function
REQ-012 The block SHALL sit between the CPU Wishbone master and the memory map, and SHALL split odd-address word accesses (byte_i=0, adr_i[0]=1) into two byte accesses.
REQ-013 Byte transfers on the downstream side SHALL carry data on bits [7:0] in both directions.
REQ-014 FSM states SHALL be IDLE, SINGLE, LO, GAP, HI and ACK; all outputs SHALL be registered.
REQ-015 IDLE with stb_i=1 SHALL latch adr_i, dat_i, we_i and byte_i, assert m_stb_o on the next cycle, and go to SINGLE if byte_i=1 or adr_i[0]=0, otherwise to LO.
REQ-016 SINGLE SHALL drive the latched address, data, we and byte unchanged.
REQ-017 On m_ack_i in SINGLE, the block SHALL capture m_dat_i into dat_o, clear m_stb_o and go to ACK.
REQ-018 LO SHALL drive m_adr_o=adr, m_byte_o=1 and m_dat_o[7:0]=dat[7:0].
REQ-019 On m_ack_i in LO, the block SHALL capture m_dat_i[7:0] into dat_o[7:0], clear m_stb_o and go to GAP.
REQ-020 GAP SHALL last exactly one cycle with m_stb_o=0, then go to HI with m_stb_o=1.
REQ-021 HI SHALL drive m_adr_o=adr+1 modulo 2^ADR_W (0xFFFFF wraps to 0x00000), m_byte_o=1 and m_dat_o[7:0]=dat[15:8].
REQ-022 On m_ack_i in HI, the block SHALL capture m_dat_i[7:0] into dat_o[15:8], clear m_stb_o and go to ACK.
REQ-023 ACK SHALL assert ack_o for exactly one cycle, then return to IDLE.
REQ-024 ack_o SHALL never be asserted in any state other than ACK.
REQ-025 Minimum latency from stb_i to ack_o SHALL be 3 cycles for a single access and 6 cycles for a split access when m_ack_i arrives one cycle after m_stb_o.
REQ-026 m_ack_i while m_stb_o=0 SHALL be ignored.
REQ-027 stb_i changes after acceptance SHALL be ignored until the block returns to IDLE.
REQ-028 On split writes, dat_o SHALL hold its previous value.

Reset
REQ-029 rst_i=1 SHALL force IDLE, m_stb_o=0, ack_o=0, dat_o=0, m_adr_o=0, m_dat_o=0, m_we_o=0 and m_byte_o=0 on the next edge, including mid-transaction; an aborted transaction SHALL NOT be acknowledged.

Structure
REQ-030 The state encoding and the ADR_W default SHALL live in the shared package.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Aligned word read, adr=0x00400, m_dat_i=0xBEEF -> one downstream access with m_byte_o=0, then ack_o with dat_o=0xBEEF.
REQ-033 Split write, adr=0x00401, dat=0x1234 -> byte write 0x34 @0x00401, m_stb_o low 1 cycle, byte write 0x12 @0x00402, then one ack_o.
REQ-034 Split read, adr=0x00401, low byte returns 0x??CD and high byte returns 0x??AB -> dat_o=0xABCD.
REQ-035 Wrap, word read at adr=0xFFFFF -> second access @0x00000.
REQ-036 rst_i asserted in HI with a delayed m_ack_i -> next cycle in IDLE with all outputs 0 and no ack_o; the following byte read @0x00003 completes normally.
